// File: rtl/conv33_pkg.sv
// Shared definitions for the conv33 pooling path: the default sample width
// and the pooling FSM state encoding.
package conv33_pkg;

    localparam int OUT_WIDTH_DEF = 32;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] S_EVEN = 2'd0;  // even row: fold column pairs into the line buffer
    localparam logic [STATE_W-1:0] S_ODD  = 2'd1;  // odd row: complete windows and emit results
    localparam logic [STATE_W-1:0] S_SKIP = 2'd2;  // unpaired trailing row of an odd-height map

endpackage

// File: rtl/conv33_pool_linebuf.sv
// Line buffer for 2x2 pooling: holds one horizontal pair maximum per output
// column. Synchronous write, combinational read. The contents are not reset
// because every entry is rewritten on an even row before it is read.
module conv33_pool_linebuf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 13,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store a pair maximum when the even row produces one
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/conv33_maxpool22.sv
// 2x2 stride-2 signed max pooling over a raster-order feature map.
// Optional feature: define CONV33_POOL_RELU_EN to clamp negative inputs to
// zero before any comparison.
module conv33_maxpool22
    import conv33_pkg::*;
#(
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int IMG_W     = 26,
    parameter int IMG_H     = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [OUT_WIDTH-1:0] in_data,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 frame_done
);

    localparam int CW       = $clog2(IMG_W);
    localparam int RW       = $clog2(IMG_H);
    localparam int LB_DEPTH = IMG_W / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam bit H_ODD = (IMG_H % 2) == 1;

    function automatic logic signed [OUT_WIDTH-1:0] smax(
        input logic signed [OUT_WIDTH-1:0] a,
        input logic signed [OUT_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] act(
        input logic signed [OUT_WIDTH-1:0] x
    );
`ifdef CONV33_POOL_RELU_EN
        return x[OUT_WIDTH-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    logic [STATE_W-1:0]          state;
    logic [STATE_W-1:0]          state_nx;
    logic [CW-1:0]               col;
    logic [RW-1:0]               row;
    logic [RW-1:0]               next_row;
    logic                        col_end;
    logic                        row_end;

    // stage 0: incoming sample and the horizontal pair maximum
    logic signed [OUT_WIDTH-1:0] sample_p0;
    logic signed [OUT_WIDTH-1:0] hold_p0;
    logic signed [OUT_WIDTH-1:0] pair_max_p0;
    logic signed [OUT_WIDTH-1:0] lb_rd_p0;
    logic [OUT_WIDTH-1:0]        lb_rd_raw;
    logic                        lb_wr_en;
    logic [LB_AW-1:0]            lb_addr;

    // stage 1: registered pooled result
    logic                        vld_p1;
    logic signed [OUT_WIDTH-1:0] out_data_p1;
    logic                        frame_done_p1;

    assign sample_p0   = act($signed(in_data));
    assign pair_max_p0 = smax(hold_p0, sample_p0);
    assign col_end     = (col == COL_LAST);
    assign row_end     = (row == ROW_LAST);
    assign lb_addr     = LB_AW'(col >> 1);
    assign lb_wr_en    = in_valid && (state == S_EVEN) && col[0];
    assign lb_rd_p0    = $signed(lb_rd_raw);

    // Next row and the state that row belongs to
    always_comb begin
        next_row = row_end ? '0 : row + RW'(1);
        state_nx = S_EVEN;
        if (row_end) begin
            state_nx = S_EVEN;
        end else if (next_row[0]) begin
            state_nx = S_ODD;
        end else if (H_ODD && (next_row == ROW_LAST)) begin
            state_nx = S_SKIP;
        end
    end

    conv33_pool_linebuf #(
        .DATA_W (OUT_WIDTH),
        .DEPTH  (LB_DEPTH),
        .AW     (LB_AW)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .wr_addr (lb_addr),
        .wr_data (pair_max_p0),
        .rd_addr (lb_addr),
        .rd_data (lb_rd_raw)
    );

    // Raster position tracking and row-parity FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_EVEN;
            col   <= '0;
            row   <= '0;
        end else if (in_valid) begin
            if (col_end) begin
                col   <= '0;
                row   <= next_row;
                state <= state_nx;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Hold the even-column sample, emit the window maximum on odd rows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_p0       <= '0;
            vld_p1        <= 1'b0;
            out_data_p1   <= '0;
            frame_done_p1 <= 1'b0;
        end else begin
            vld_p1        <= 1'b0;
            frame_done_p1 <= 1'b0;
            if (in_valid) begin
                if (!col[0] && (state != S_SKIP)) begin
                    hold_p0 <= sample_p0;
                end
                if ((state == S_ODD) && col[0]) begin
                    vld_p1      <= 1'b1;
                    out_data_p1 <= smax(lb_rd_p0, pair_max_p0);
                end
                frame_done_p1 <= col_end && row_end;
            end
        end
    end

    assign out_valid  = vld_p1;
    assign out_data   = out_data_p1;
    assign frame_done = frame_done_p1;

endmodule

// File: doc/conv33_maxpool22.md
CONV33_MAXPOOL22 -- requirements
Module: conv33_maxpool22

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 32: width of signed input and output samples.
REQ-002 SHALL have parameter IMG_W, default 26: input feature-map width in samples, ≥2.
REQ-003 SHALL have parameter IMG_H, default 26: input feature-map height in rows, ≥2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  sample strobe from the upstream conv33 output buffer.
REQ-007 SHALL have port in_data  input  OUT_WIDTH  signed sample, raster order, row-major.
REQ-008 SHALL have port out_valid  output  1  one-cycle strobe per pooled sample.
REQ-009 SHALL have port out_data  output  OUT_WIDTH  signed pooled sample.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse after the last input sample of a frame.

Function
REQ-011 SHALL implement 2x2 stride-2 max pooling, producing (IMG_W/2)x(IMG_H/2) outputs per frame, integer division.
REQ-012 SHALL have no backpressure; every in_valid cycle consumes exactly one sample; idle cycles between samples are allowed and change no state.
REQ-013 SHALL track column col (0..IMG_W-1) and row row (0..IMG_H-1), advancing col per accepted sample and wrapping to 0 with row increment; after row IMG_H-1, col IMG_W-1, both wrap to 0.
REQ-014 SHALL use FSM states S_EVEN (row even), S_ODD (row odd), S_SKIP (trailing row when IMG_H odd); S_EVEN->S_ODD and S_ODD->S_EVEN at row end; S_ODD->S_SKIP at row end when next row is IMG_H-1 and IMG_H is odd; S_SKIP->S_EVEN at frame end.
REQ-015 SHALL, in S_EVEN, hold even-col samples in register hold and, on odd col, write max(hold, in_data) to line buffer entry col/2.
REQ-016 SHALL, in S_ODD, hold even-col samples and, on odd col, assert out_valid the next cycle with out_data = max(linebuf[col/2], hold, in_data).
REQ-017 SHALL have latency exactly 1 cycle from the accepted 4th sample of a window to out_valid.
REQ-018 SHALL discard the trailing column when IMG_W is odd and all S_SKIP samples; no output or line-buffer write occurs for them.
REQ-019 SHALL compare as two's-complement signed; equal values yield that value; no width growth.
REQ-020 SHALL pulse frame_done in the cycle after the sample at row IMG_H-1, col IMG_W-1 is accepted, coincident with the final out_valid when IMG_H and IMG_W are even.
REQ-021 SHALL hold out_data at its last value when out_valid is 0.

Reset
REQ-022 SHALL, on rst low, asynchronously force out_valid=0, out_data=0, frame_done=0, col=0, row=0, hold=0, state=S_EVEN.
REQ-023 SHALL NOT reset line-buffer contents; each entry is written in S_EVEN before it is read in S_ODD.
REQ-024 SHALL, on reset mid-frame, abandon the partial frame; the first sample after release is row 0, col 0.

Configuration
REQ-025 SHALL, with CONV33_POOL_RELU_EN defined, clamp each negative in_data to 0 before any compare, making all outputs ≥0.
REQ-026 SHALL, without CONV33_POOL_RELU_EN, pool raw signed values.

Structure
REQ-027 SHALL take OUT_WIDTH default and FSM state encoding from shared package conv33_pkg.
REQ-028 SHALL instantiate sub-module conv33_pool_linebuf: IMG_W/2 entries x OUT_WIDTH, one synchronous write port, one combinational read port, no reset.

Verification
REQ-029 SHALL cover 4x4 map, values 0..15 raster -> outputs 5,7,13,15, each 1 cycle after its window's last sample; frame_done with the 15 output.
REQ-030 SHALL cover all-negative 4x4 map (-1..-16) -> outputs -1,-3,-9,-11 without CONV33_POOL_RELU_EN; 0,0,0,0 with it.
REQ-031 SHALL cover 5x5 map of 0..24 -> outputs 6,8,16,18; column 4 and row 4 dropped; frame_done after sample 24.
REQ-032 SHALL cover the 4x4 case with random 0-3 cycle in_valid gaps -> identical outputs, one out_valid pulse each.
REQ-033 SHALL cover rst low after 6 samples, then a full 4x4 frame of 0..15 -> exactly 5,7,13,15; no output from the partial frame.
REQ-034 SHALL cover two back-to-back 4x4 frames -> 8 outputs, two frame_done pulses, with row/col wrapping verified.
